onchip_mem_arbiter: RTL
=======================

# onchip_mem_arbiter

Two-port round-robin arbiter that shares the single-port 32-bit on-chip RAM (17-bit word address, 4-bit byteenable, one-cycle unregistered read) between two Avalon-MM requesters, e.g. the Nios II data master and a DMA master. It sits between the requesters and the RAM. It serialises accesses, returns read data to the requester that issued the read, and blocks any access outside the populated depth.

## Interface
- DEPTH, 100000: number of populated 32-bit words; valid addresses are 0..DEPTH-1.
- ERR_DATA, 32'h0000_0000: read data returned for an out-of-range read.
- clk  in  1  single system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mX_address  in  17  word address of requester X (X = 0, 1).
- mX_read  in  1  read request of requester X.
- mX_write  in  1  write request of requester X.
- mX_byteenable  in  4  byte lanes for writes.
- mX_writedata  in  32  write data.
- mX_waitrequest  out  1  high while the request is not accepted this cycle.
- mX_readdata  out  32  returned read data; registered.
- mX_readdatavalid  out  1  one-cycle strobe qualifying mX_readdata.
- mem_address  out  17  RAM address.
- mem_byteenable  out  4  RAM byte enables.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write strobe.
- mem_writedata  out  32  RAM write data.
- mem_clken  out  1  RAM clock enable.
- mem_readdata  in  32  RAM q, valid the cycle after the address is presented.
- oor_pulse  out  1  registered one-cycle pulse per blocked out-of-range access.
- oor_count  out  16  saturating count of blocked accesses.

## Operation
- A requester is active when mX_read or mX_write is high. When both read and write are high, the request is treated as a write.
- Arbitration is combinational in the same cycle:
  - One active requester: that requester is granted.
  - Both active: the requester not recorded in last_grant is granted.
- last_grant is updated on every grant.
- The granted requester sees mX_waitrequest=0 and is accepted on that clock edge. A non-granted active requester sees waitrequest=1 and must hold its request stable.
- An idle requester sees waitrequest=1.
- For the granted request, mem_address, mem_byteenable and mem_writedata are muxed from the granted requester.
  - mem_chipselect=1.
  - mem_write=1 for writes.
- With no grant: mem_chipselect=0 and mem_write=0. The data and address outputs hold the requester-0 values (don't-care).
- mem_clken=1 whenever reset_n is high.
- Out-of-range access (address >= DEPTH):
  - Still granted and accepted, with the normal waitrequest behaviour.
  - mem_chipselect and mem_write are forced to 0, so the RAM is not touched.
  - oor_pulse is asserted the next cycle, and oor_count increments, saturating at 16'hFFFF.
  - An out-of-range read returns ERR_DATA with the normal latency.
- A two-stage tag pipeline records, for each accepted read, its owner and an out-of-range flag. Writes carry no tag.
- Read data returns strictly in acceptance order, and only to the owning requester.

## Timing
- Accepted read in cycle N:
  - The RAM registers the address at the end of N, and mem_readdata is valid in N+1.
  - The arbiter registers the data (or ERR_DATA) at the end of N+1.
  - mX_readdatavalid=1 with mX_readdata in N+2. Read latency is 2 cycles, fixed.
- Pipelined operation: one access accepted per cycle, in any read/write mix, with no bubbles.
- A write accepted in N is committed to the RAM at the end of N.
- A read of the same address in N+1 returns the new data.
- Both requesters active every cycle: grants alternate 0,1,0,1…
- Reset values: last_grant=1 (so requester 0 wins the first tie), tag pipeline empty, mX_readdatavalid=0, mX_readdata=0, oor_pulse=0, oor_count=0.
- While reset_n is low: mem_chipselect=0, mem_write=0, mem_clken=0, mX_waitrequest=1.
- Reset asserted mid-operation: all in-flight reads are discarded and no readdatavalid is produced for them. After deassertion the first valid edge accepts new requests.

## Test plan
- Single read: m0 writes 0xCAFEF00D to address 5, then reads address 5 -> waitrequest=0 both times; m0_readdatavalid exactly 2 cycles after read acceptance, with data 0xCAFEF00D; m1_readdatavalid stays 0.
- Contention: m0 and m1 continuously read addresses 10 and 20 (preloaded 0xA, 0x14) -> grants alternate 0,1,0,…; each requester gets readdatavalid every other cycle with its own data; no lost or crossed data.
- Byte lanes: write 0x11223344 with byteenable 4'b0101 over 0xFFFFFFFF -> readback is 0xFF22FF44.
- Out of range: m1 writes address 100000, then reads address 131071 -> mem_chipselect stays 0; oor_pulse fires twice; oor_count=2; m1 read returns ERR_DATA after 2 cycles.
- Read-after-write hazard: m0 writes 0x1 to address 7 in cycle N, m1 reads address 7 in N+1 -> m1 receives 0x1.
- Reset mid-flight: reset_n is pulled low the cycle after a read is accepted -> no readdatavalid; all outputs return to their reset values; the first post-reset tie is granted to m0.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
`timescale 1ns/1ps
// onchip_mem_arbiter
// Round-robin arbiter sharing one single-port 32-bit on-chip RAM between two
// Avalon-MM requesters. Out-of-range accesses are accepted but never reach the
// RAM. Read data is returned in acceptance order to the requester that issued it.
module onchip_mem_arbiter #(
  parameter int unsigned DEPTH    = 100000,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic [16:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [3:0]  m0_byteenable,
  input  logic [31:0] m0_writedata,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,

  input  logic [16:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [3:0]  m1_byteenable,
  input  logic [31:0] m1_writedata,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,

  output logic [16:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic        mem_clken,
  input  logic [31:0] mem_readdata,

  output logic        oor_pulse,
  output logic [15:0] oor_count
);

  // last_grant: 0 = requester 0 was granted last, 1 = requester 1
  logic        last_grant;
  logic        act0, act1;
  logic        grant0, grant1, granted;
  logic        sel_write, sel_oor;
  logic [16:0] sel_addr;

  // First tag stage: read accepted last cycle, whose RAM data is valid now
  logic        rd_valid;
  logic        rd_owner;
  logic        rd_oor;

  // Same-cycle arbitration and request mux; nothing is granted while in reset
  always_comb begin
    act0      = m0_read | m0_write;
    act1      = m1_read | m1_write;
    grant0    = reset_n & act0 & (~act1 | last_grant);
    grant1    = reset_n & act1 & (~act0 | ~last_grant);
    granted   = grant0 | grant1;
    sel_addr  = grant1 ? m1_address : m0_address;
    sel_write = grant1 ? m1_write   : m0_write;
    sel_oor   = ({15'd0, sel_addr} >= DEPTH);
  end

  assign m0_waitrequest = ~grant0;
  assign m1_waitrequest = ~grant1;

  assign mem_address    = sel_addr;
  assign mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = grant1 ? m1_writedata  : m0_writedata;
  assign mem_chipselect = granted & ~sel_oor;
  assign mem_write      = granted & sel_write & ~sel_oor;
  assign mem_clken      = reset_n;

  // Round-robin pointer; reset to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (grant0) begin
      last_grant <= 1'b0;
    end else if (grant1) begin
      last_grant <= 1'b1;
    end
  end

  // Tag the accepted read with its owner and range status while the RAM fetches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_owner <= 1'b0;
      rd_oor   <= 1'b0;
    end else begin
      rd_valid <= granted & ~sel_write;
      rd_owner <= grant1;
      rd_oor   <= sel_oor;
    end
  end

  // Register returned data toward the owning requester only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
      m0_readdata      <= 32'h0;
      m1_readdata      <= 32'h0;
    end else begin
      m0_readdatavalid <= rd_valid & ~rd_owner;
      m1_readdatavalid <= rd_valid & rd_owner;
      if (rd_valid && !rd_owner) begin
        m0_readdata <= rd_oor ? ERR_DATA : mem_readdata;
      end
      if (rd_valid && rd_owner) begin
        m1_readdata <= rd_oor ? ERR_DATA : mem_readdata;
      end
    end
  end

  // Flag and count blocked out-of-range accesses, count saturates
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oor_pulse <= 1'b0;
      oor_count <= 16'h0;
    end else begin
      oor_pulse <= granted & sel_oor;
      if (granted && sel_oor && (oor_count != 16'hFFFF)) begin
        oor_count <= oor_count + 16'd1;
      end
    end
  end

endmodule
